// File: rtl/io_bus_master_if.sv
// Bridge-side bus of io_bus_master: strobes, address/data paths and the pending
// interrupt flag. The d_bus tri-state buffer lives outside the master.
interface io_bus_master_if;
    logic        read;
    logic        write;
    logic        push;
    logic        push_ints;
    logic        push_int_addr;
    logic        store_retaddr;
    logic        push_retaddr;
    logic        interrupt;
    logic [15:0] addr_out;
    logic [15:0] addr_in;
    logic [15:0] bus_out;
    logic        bus_oe;
    logic [15:0] bus_in;

    modport master (
        output read, write, push, push_ints, push_int_addr, store_retaddr, push_retaddr,
        output addr_out, bus_out, bus_oe,
        input  interrupt, addr_in, bus_in
    );

    modport slave (
        input  read, write, push, push_ints, push_int_addr, store_retaddr, push_retaddr,
        input  addr_out, bus_out, bus_oe,
        output interrupt, addr_in, bus_in
    );
endinterface

// File: rtl/io_bus_master.sv
// CPU-to-I/O bridge master: sequences reads, writes, interrupt entry and
// return-from-interrupt over the bridge strobes. All outputs are registered.
module io_bus_master (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [15:0]            cpu_addr,
    input  logic [15:0]            cpu_wdata,
    output logic [15:0]            cpu_rdata,
    output logic                   cpu_ack,
    output logic                   bus_err,
    input  logic [15:0]            cur_pc,
    input  logic                   int_enable,
    input  logic                   cpu_reti,
    output logic [15:0]            ret_pc,
    output logic                   ret_valid,
    output logic                   irq_taken,
    output logic [15:0]            irq_vector,
    output logic [15:0]            irq_mask,
    io_bus_master_if.master        bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RD        = 4'd1,
        S_RD_PUSH   = 4'd2,
        S_WR        = 4'd3,
        S_DONE      = 4'd4,
        S_INT_SAVE  = 4'd5,
        S_INT_MASK  = 4'd6,
        S_INT_VEC   = 4'd7,
        S_INT_DONE  = 4'd8,
        S_RETI      = 4'd9,
        S_RETI_DONE = 4'd10
    } state_t;

    state_t      state_r, next_state_s;

    // strobe bit order: read, write, push, push_ints, push_int_addr, store_retaddr, push_retaddr
    logic [6:0]  strobe_r, strobe_s;
    logic [15:0] addr_out_r, addr_out_s, bus_out_r, bus_out_s;
    logic        bus_oe_r, bus_oe_s, cpu_ack_r, cpu_ack_s, bus_err_r, bus_err_s;
    logic        ret_valid_r, ret_valid_s, irq_taken_r, irq_taken_s;
    logic [15:0] cpu_rdata_r, cpu_rdata_s, ret_pc_r, ret_pc_s;
    logic [15:0] irq_vector_r, irq_vector_s, irq_mask_r, irq_mask_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; interrupt entry outranks reti, which outranks a CPU request
    always_comb begin
        next_state_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (bus.interrupt && int_enable) begin
                    next_state_s = S_INT_SAVE;
                end else if (cpu_reti) begin
                    next_state_s = S_RETI;
                end else if (cpu_req) begin
                    if (cpu_addr == 16'h0000) begin
                        next_state_s = S_DONE;
                    end else if (cpu_we) begin
                        next_state_s = S_WR;
                    end else begin
                        next_state_s = S_RD;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_RD:        next_state_s = S_RD_PUSH;
            S_RD_PUSH:   next_state_s = S_DONE;
            S_WR:        next_state_s = S_DONE;
            S_DONE:      next_state_s = S_IDLE;
            S_INT_SAVE:  next_state_s = S_INT_MASK;
            S_INT_MASK:  next_state_s = S_INT_VEC;
            S_INT_VEC:   next_state_s = S_INT_DONE;
            S_INT_DONE:  next_state_s = S_IDLE;
            S_RETI:      next_state_s = S_RETI_DONE;
            S_RETI_DONE: next_state_s = S_IDLE;
            default:     next_state_s = S_IDLE;
        endcase
    end

    // Output logic: decoded from the state being entered so registered outputs line up with it
    always_comb begin
        strobe_s     = 7'b0000000;
        addr_out_s   = 16'h0000;
        bus_out_s    = 16'h0000;
        bus_oe_s     = 1'b0;
        cpu_ack_s    = 1'b0;
        bus_err_s    = 1'b0;
        ret_valid_s  = 1'b0;
        irq_taken_s  = 1'b0;
        cpu_rdata_s  = cpu_rdata_r;
        ret_pc_s     = ret_pc_r;
        irq_vector_s = irq_vector_r;
        irq_mask_s   = irq_mask_r;

        case (next_state_s)
            S_RD: begin
                strobe_s   = 7'b1000000;
                addr_out_s = cpu_addr;
            end
            S_RD_PUSH: begin
                strobe_s   = 7'b0010000;
                addr_out_s = addr_out_r;
            end
            S_WR: begin
                strobe_s   = 7'b0100000;
                addr_out_s = cpu_addr;
                bus_out_s  = cpu_wdata;
                bus_oe_s   = 1'b1;
            end
            S_DONE: begin
                cpu_ack_s = 1'b1;
                if (state_r == S_IDLE) begin
                    bus_err_s = 1'b1;
                end else begin
                    bus_err_s = 1'b0;
                end
            end
            S_INT_SAVE: begin
                strobe_s  = 7'b0000010;
                bus_out_s = cur_pc;
                bus_oe_s  = 1'b1;
            end
            S_INT_MASK:  strobe_s    = 7'b0001000;
            S_INT_VEC:   strobe_s    = 7'b0000100;
            S_INT_DONE:  irq_taken_s = 1'b1;
            S_RETI:      strobe_s    = 7'b0000001;
            S_RETI_DONE: ret_valid_s = 1'b1;
            default:     strobe_s    = 7'b0000000;
        endcase

        // Bridge data is captured at the end of the cycle its strobe was high
        case (state_r)
            S_IDLE: begin
                if (next_state_s == S_DONE) begin
                    cpu_rdata_s = 16'h0000;
                end else begin
                    cpu_rdata_s = cpu_rdata_r;
                end
            end
            S_RD_PUSH:  cpu_rdata_s  = bus.bus_in;
            S_INT_MASK: irq_mask_s   = bus.bus_in;
            S_INT_VEC:  irq_vector_s = bus.addr_in;
            S_RETI:     ret_pc_s     = bus.bus_in;
            default:    cpu_rdata_s  = cpu_rdata_r;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_r     <= 7'b0000000;
            addr_out_r   <= 16'h0000;
            bus_out_r    <= 16'h0000;
            bus_oe_r     <= 1'b0;
            cpu_ack_r    <= 1'b0;
            bus_err_r    <= 1'b0;
            ret_valid_r  <= 1'b0;
            irq_taken_r  <= 1'b0;
            cpu_rdata_r  <= 16'h0000;
            ret_pc_r     <= 16'h0000;
            irq_vector_r <= 16'h0000;
            irq_mask_r   <= 16'h0000;
        end else begin
            strobe_r     <= strobe_s;
            addr_out_r   <= addr_out_s;
            bus_out_r    <= bus_out_s;
            bus_oe_r     <= bus_oe_s;
            cpu_ack_r    <= cpu_ack_s;
            bus_err_r    <= bus_err_s;
            ret_valid_r  <= ret_valid_s;
            irq_taken_r  <= irq_taken_s;
            cpu_rdata_r  <= cpu_rdata_s;
            ret_pc_r     <= ret_pc_s;
            irq_vector_r <= irq_vector_s;
            irq_mask_r   <= irq_mask_s;
        end
    end

    assign bus.read          = strobe_r[6];
    assign bus.write         = strobe_r[5];
    assign bus.push          = strobe_r[4];
    assign bus.push_ints     = strobe_r[3];
    assign bus.push_int_addr = strobe_r[2];
    assign bus.store_retaddr = strobe_r[1];
    assign bus.push_retaddr  = strobe_r[0];
    assign bus.addr_out      = addr_out_r;
    assign bus.bus_out       = bus_out_r;
    assign bus.bus_oe        = bus_oe_r;
    assign cpu_ack           = cpu_ack_r;
    assign bus_err           = bus_err_r;
    assign cpu_rdata         = cpu_rdata_r;
    assign ret_pc            = ret_pc_r;
    assign ret_valid         = ret_valid_r;
    assign irq_taken         = irq_taken_r;
    assign irq_vector        = irq_vector_r;
    assign irq_mask          = irq_mask_r;

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port cpu_req, input, 1 bit: CPU I/O request, held high until cpu_ack.
REQ-004 SHALL have port cpu_we, input, 1 bit: 1 = write, 0 = read; valid with cpu_req.
REQ-005 SHALL have port cpu_addr, input, 16 bits: one-hot device select.
REQ-006 SHALL have port cpu_wdata, input, 16 bits: write data.
REQ-007 SHALL have port cpu_rdata, output, 16 bits: read data, valid while cpu_ack is high.
REQ-008 SHALL have port cpu_ack, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port bus_err, output, 1 bit: one-cycle pulse with cpu_ack when cpu_addr == 0.
REQ-010 SHALL have ports cur_pc (input, 16 bits), the return address to save, and int_enable (input, 1 bit), which gates interrupt entry.
REQ-011 SHALL have port cpu_reti, input, 1 bit: single-cycle return-from-interrupt request.
REQ-012 SHALL have ports ret_pc (output, 16 bits) and ret_valid (output, 1 bit), the restored PC and its one-cycle valid pulse.
REQ-013 SHALL have ports irq_taken (output, 1 bit, one-cycle pulse), irq_vector (output, 16 bits) and irq_mask (output, 16 bits).
REQ-014 SHALL have bridge strobe outputs read, write, push, push_ints, push_int_addr, store_retaddr and push_retaddr, each 1 bit, at most one high per cycle.
REQ-015 SHALL have bridge input interrupt, 1 bit: level-sensitive pending flag.
REQ-016 SHALL have ports addr_out (output, 16 bits) and addr_in (input, 16 bits), the driven and sampled d_addr.
REQ-017 SHALL have ports bus_out (output, 16 bits), bus_oe (output, 1 bit) and bus_in (input, 16 bits), the driven and sampled d_bus, with the tri-state buffer instantiated outside this block.

Function
REQ-018 SHALL implement states IDLE, RD, RD_PUSH, WR, DONE, INT_SAVE, INT_MASK, INT_VEC, INT_DONE, RETI, RETI_DONE.
REQ-019 SHALL, in IDLE, apply this priority: interrupt && int_enable → INT_SAVE; else cpu_reti → RETI; else cpu_req → request path; else stay in IDLE.
REQ-020 SHALL, for a request with cpu_addr == 0, go to DONE with cpu_ack=1, bus_err=1 and cpu_rdata=0, issuing no bridge strobe.
REQ-021 SHALL, for a read, sequence RD (read=1) → RD_PUSH (push=1, sample bus_in at its end) → DONE (cpu_ack=1, cpu_rdata = sample), so cpu_ack rises 3 cycles after acceptance.
REQ-022 SHALL, for a write, sequence WR (write=1, bus_oe=1, bus_out=cpu_wdata) → DONE (cpu_ack=1), so cpu_ack rises 2 cycles after acceptance.
REQ-023 SHALL hold addr_out = cpu_addr, latched at acceptance, throughout RD, RD_PUSH and WR, and drive addr_out=0 otherwise.
REQ-024 SHALL return from DONE to IDLE unconditionally, so a request still held high is not re-accepted until the cycle after DONE.
REQ-025 SHALL, for interrupt entry, sequence: INT_SAVE (store_retaddr=1, bus_oe=1, bus_out=cur_pc); INT_MASK (push_ints=1, irq_mask ← bus_in); INT_VEC (push_int_addr=1, irq_vector ← addr_in); INT_DONE (irq_taken=1); then IDLE.
REQ-026 SHALL ignore interrupt, cpu_req and cpu_reti while in any INT_* state, leaving a pending cpu_req to be serviced after INT_DONE.
REQ-027 SHALL, for cpu_reti, sequence RETI (push_retaddr=1, sample bus_in) → RETI_DONE (ret_valid=1, ret_pc = sample) → IDLE.
REQ-028 SHALL drive bus_oe high only in WR and INT_SAVE.
REQ-029 SHALL not accept a cpu_reti asserted outside IDLE; the CPU re-issues it.
REQ-030 SHALL hold cpu_rdata, ret_pc, irq_vector and irq_mask until next overwritten.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force the state to IDLE and set all strobes, bus_oe, cpu_ack, bus_err, irq_taken and ret_valid to 0.
REQ-032 SHALL clear cpu_rdata, ret_pc, irq_vector, irq_mask, addr_out and bus_out to 0 on reset.
REQ-033 SHALL abort any in-progress transaction on a reset mid-operation, with no cpu_ack issued; the first operation after rst_n rises is accepted on the first clock edge.

Verification
REQ-034 SHALL be verified by a read test: cpu_req=1, cpu_we=0, cpu_addr=0x0004, test_io returns 37 → read at cycle 1, push at cycle 2, cpu_ack with cpu_rdata=0x0025 at cycle 3.
REQ-035 SHALL be verified by a write test: cpu_we=1, cpu_addr=0x0001, cpu_wdata=0x00A5 → write=1, bus_oe=1, bus_out=0x00A5 for one cycle, then cpu_ack.
REQ-036 SHALL be verified by an interrupt test: interrupt=1, int_enable=1, cur_pc=0x1234, bridge returns 0x0004 as mask and 0x0002 as vector → store_retaddr with bus_out=0x1234, then irq_mask=0x0004, irq_vector=0x0002, and irq_taken pulses 4 cycles after entry.
REQ-037 SHALL be verified by a collision test: cpu_req and interrupt rise in the same cycle → the full interrupt sequence runs first, then the read, and cpu_ack occurs exactly once.
REQ-038 SHALL be verified by a null-address test: cpu_addr=0 → cpu_ack=1 and bus_err=1 one cycle after acceptance, no strobes, cpu_rdata=0.
REQ-039 SHALL be verified by a reset-abort test: rst_n driven low during RD_PUSH → push drops immediately without waiting for a clock edge, and no cpu_ack is issued; after reset a cpu_reti with bridge retaddr 0x1234 produces ret_valid with ret_pc=0x1234.
